// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer driving a
// shared-ALU/shared-memory datapath, with memory handshake timeout and retired-instruction count.
module multicycle_ctrl_fsm #(
  parameter bit          MEM_HS  = 1'b1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [2:0]       compare,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemoryWrite,
  output logic             IRWrite,
  output logic             RegFetch,
  output logic             RegWrite,
  output logic             ALUOutRegWrite,
  output logic             S_rs1,
  output logic             S_func3,
  output logic             S_PC,
  output logic [1:0]       S_rs2,
  output logic [1:0]       S_sub,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state_o,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t              state, next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                mem_done, timed_out, legal, taken, retire;
  logic                set_illegal, set_bus_err;

  // Without a handshake every access completes in its first cycle and can never time out.
  assign mem_done  = !MEM_HS || mem_ready;
  assign timed_out = MEM_HS && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign state_o   = state;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_BRANCH: legal = (func3[2:1] != 2'b01);
      default:   legal = 1'b0;
    endcase
  end

  // compare = {ltu, lt, eq}; func3[0] inverts the sense (BNE/BGE/BGEU).
  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000: taken =  compare[0];
      3'b001: taken = !compare[0];
      3'b100: taken =  compare[1];
      3'b101: taken = !compare[1];
      3'b110: taken =  compare[2];
      3'b111: taken = !compare[2];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state     = state;
    set_illegal    = 1'b0;
    set_bus_err    = 1'b0;
    mem_req        = 1'b0;
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    IorD           = 1'b0;
    MemoryWrite    = 1'b0;
    IRWrite        = 1'b0;
    RegFetch       = 1'b0;
    RegWrite       = 1'b0;
    ALUOutRegWrite = 1'b0;
    S_rs1          = 1'b0;
    S_func3        = 1'b0;
    S_PC           = 1'b0;
    S_rs2          = 2'b00;
    S_sub          = 2'b00;
    wb_sel         = 2'b00;
    // Controls are forced low for as long as clr is held, not just after the state resets.
    if (clr) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_done) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            S_rs2      = 2'b01;
            next_state = S_DECODE;
          end else if (timed_out) begin
            set_bus_err = 1'b1;
            next_state  = S_TRAP;
          end
        end
        S_DECODE: begin
          RegFetch       = 1'b1;
          ALUOutRegWrite = 1'b1;
          S_rs2          = 2'b10;
          if (legal) begin
            next_state = S_EXEC;
          end else begin
            set_illegal = 1'b1;
            next_state  = S_TRAP;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_R, OP_I: begin
              S_rs1          = 1'b1;
              S_rs2          = (opcode == OP_I) ? 2'b10 : 2'b00;
              S_sub          = 2'b01;
              S_func3        = 1'b1;
              ALUOutRegWrite = 1'b1;
              next_state     = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              S_rs1          = 1'b1;
              S_rs2          = 2'b10;
              ALUOutRegWrite = 1'b1;
              next_state     = S_MEM;
            end
            OP_BRANCH: begin
              S_rs1       = 1'b1;
              S_sub       = 2'b10;
              S_PC        = 1'b1;
              PCWriteCond = taken;
              next_state  = S_FETCH;
            end
            OP_JAL: begin
              PCWrite    = 1'b1;
              S_PC       = 1'b1;
              next_state = S_WB;
            end
            OP_JALR: begin
              S_rs1      = 1'b1;
              S_rs2      = 2'b10;
              PCWrite    = 1'b1;
              next_state = S_WB;
            end
            OP_LUI: begin
              S_rs2          = 2'b10;
              ALUOutRegWrite = 1'b1;
              next_state     = S_WB;
            end
            OP_AUIPC: next_state = S_WB;
            default: begin
              set_illegal = 1'b1;
              next_state  = S_TRAP;
            end
          endcase
        end
        S_MEM: begin
          mem_req     = 1'b1;
          IorD        = 1'b1;
          MemoryWrite = (opcode == OP_STORE);
          if (mem_done) begin
            next_state = (opcode == OP_STORE) ? S_FETCH : S_WB;
          end else if (timed_out) begin
            set_bus_err = 1'b1;
            next_state  = S_TRAP;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          if (opcode == OP_LOAD)                           wb_sel = 2'b01;
          else if (opcode == OP_JAL || opcode == OP_JALR)  wb_sel = 2'b10;
          next_state = S_FETCH;
        end
        default: next_state = S_TRAP;
      endcase
    end
  end

  assign retire = (next_state == S_FETCH) &&
                  (state == S_EXEC || state == S_MEM || state == S_WB);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= next_state;
      // Any state change clears the counter, so it restarts on every entry to FETCH/MEM.
      if (next_state != state)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)      instret <= instret + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized self-checking bench for multicycle_ctrl_fsm against an instruction-level
// reference model; a second instance covers the no-handshake mode and instret wrap.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic       mem_req, pc_write, pc_cond, iord, mem_write, ir_write;
    logic       reg_fetch, reg_write, aluout_we, s_rs1, s_func3, s_pc;
    logic [1:0] s_rs2, s_sub, wb_sel;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [6:0]  opcode = 7'h33;
  logic [2:0]  func3 = '0;
  logic [2:0]  compare = '0;
  logic        mem_ready = 1'b0;

  logic        mem_req, PCWrite, PCWriteCond, IorD, MemoryWrite, IRWrite, RegFetch;
  logic        RegWrite, ALUOutRegWrite, S_rs1, S_func3, S_PC, illegal, bus_err;
  logic [1:0]  S_rs2, S_sub, wb_sel;
  logic [2:0]  state_o;
  logic [31:0] instret;

  logic        d2_mem_req, d2_PCWrite, d2_PCWriteCond, d2_IorD, d2_MemoryWrite, d2_IRWrite;
  logic        d2_RegFetch, d2_RegWrite, d2_ALUOutRegWrite, d2_S_rs1, d2_S_func3, d2_S_PC;
  logic        d2_illegal, d2_bus_err;
  logic [1:0]  d2_S_rs2, d2_S_sub, d2_wb_sel;
  logic [2:0]  d2_state_o;
  logic [2:0]  d2_instret;

  ctrl_t act;
  assign act = {mem_req, PCWrite, PCWriteCond, IorD, MemoryWrite, IRWrite,
                RegFetch, RegWrite, ALUOutRegWrite, S_rs1, S_func3, S_PC,
                S_rs2, S_sub, wb_sel};

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret = '0;
  logic        exp_illegal = 1'b0;
  logic        exp_bus = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_HS(1'b1), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .clr(clr), .opcode(opcode), .func3(func3), .compare(compare),
    .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemoryWrite(MemoryWrite), .IRWrite(IRWrite), .RegFetch(RegFetch),
    .RegWrite(RegWrite), .ALUOutRegWrite(ALUOutRegWrite), .S_rs1(S_rs1), .S_func3(S_func3),
    .S_PC(S_PC), .S_rs2(S_rs2), .S_sub(S_sub), .wb_sel(wb_sel), .state_o(state_o),
    .illegal(illegal), .bus_err(bus_err), .instret(instret));

  multicycle_ctrl_fsm #(.MEM_HS(1'b0), .TIMEOUT(4), .CNT_W(3)) dut2 (
    .clk(clk), .clr(clr), .opcode(opcode), .func3(func3), .compare(compare),
    .mem_ready(mem_ready), .mem_req(d2_mem_req), .PCWrite(d2_PCWrite),
    .PCWriteCond(d2_PCWriteCond), .IorD(d2_IorD), .MemoryWrite(d2_MemoryWrite),
    .IRWrite(d2_IRWrite), .RegFetch(d2_RegFetch), .RegWrite(d2_RegWrite),
    .ALUOutRegWrite(d2_ALUOutRegWrite), .S_rs1(d2_S_rs1), .S_func3(d2_S_func3),
    .S_PC(d2_S_PC), .S_rs2(d2_S_rs2), .S_sub(d2_S_sub), .wb_sel(d2_wb_sel),
    .state_o(d2_state_o), .illegal(d2_illegal), .bus_err(d2_bus_err), .instret(d2_instret));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst_state", 64'(state_o), 64'(0));
    check("rst_ctrl", 64'(act), 64'(0));
    check("rst_instret", 64'(instret), 64'(0));
    check("rst_flags", 64'({illegal, bus_err}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    exp_instret = '0;
    exp_illegal = 1'b0;
    exp_bus = 1'b0;
  endtask

  task automatic check_trap();
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("trap_state", 64'(state_o), 64'(5));
      check("trap_ctrl", 64'(act), 64'(0));
      check("trap_flags", 64'({illegal, bus_err}), 64'({exp_illegal, exp_bus}));
      tick();
    end
  endtask

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic ok = 1'b0;
    foreach (ops[i]) if (ops[i] == op) ok = 1'b1;
    if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) ok = 1'b0;
    return ok;
  endfunction

  // One instruction from FETCH to its return to FETCH (or TRAP); dead=1 means it trapped.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] cmp,
                           input int fdly, input int mdly, input int abort, output bit dead);
    ctrl_t e;
    logic  sel, taken;
    dead = 1'b0;
    opcode = op;
    func3 = f3;
    compare = cmp;
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      mem_ready = (k == fdly);
      @(negedge clk);
      e = '0;
      e.mem_req = 1'b1;
      if (k == fdly) begin
        e.ir_write = 1'b1; e.pc_write = 1'b1; e.s_rs2 = 2'b01;
      end
      check("fetch_state", 64'(state_o), 64'(0));
      check("fetch_ctrl", 64'(act), 64'(e));
      tick();
      if (k == fdly) break;
    end
    mem_ready = 1'b0;
    if (fdly >= int'(TIMEOUT)) begin
      exp_bus = 1'b1;
      dead = 1'b1;
      return;
    end

    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    e = '0;
    e.reg_fetch = 1'b1; e.aluout_we = 1'b1; e.s_rs2 = 2'b10;
    check("decode_state", 64'(state_o), 64'(1));
    check("decode_ctrl", 64'(act), 64'(e));
    tick();
    if (!is_legal(op, f3)) begin
      exp_illegal = 1'b1;
      dead = 1'b1;
      return;
    end

    sel = f3[2] ? (f3[1] ? cmp[2] : cmp[1]) : cmp[0];
    taken = sel ^ f3[0];
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    e = '0;
    case (op)
      7'h33, 7'h13: begin
        e.s_rs1 = 1'b1; e.s_sub = 2'b01; e.s_func3 = 1'b1; e.aluout_we = 1'b1;
        e.s_rs2 = (op == 7'h13) ? 2'b10 : 2'b00;
      end
      7'h03, 7'h23: begin e.s_rs1 = 1'b1; e.s_rs2 = 2'b10; e.aluout_we = 1'b1; end
      7'h63: begin e.s_rs1 = 1'b1; e.s_sub = 2'b10; e.s_pc = 1'b1; e.pc_cond = taken; end
      7'h6F: begin e.pc_write = 1'b1; e.s_pc = 1'b1; end
      7'h67: begin e.s_rs1 = 1'b1; e.s_rs2 = 2'b10; e.pc_write = 1'b1; end
      7'h37: begin e.s_rs2 = 2'b10; e.aluout_we = 1'b1; end
      default: e = '0;
    endcase
    check("exec_state", 64'(state_o), 64'(2));
    check("exec_ctrl", 64'(act), 64'(e));
    tick();
    if (op == 7'h63) begin
      exp_instret++;
      check("instret", 64'(instret), 64'(exp_instret));
      return;
    end

    if (op == 7'h03 || op == 7'h23) begin
      for (int k = 0; k < int'(TIMEOUT); k++) begin
        if (k == abort) begin
          check("abort_pre_wr", 64'(MemoryWrite), 64'(1));
          clr = 1'b0;
          #1;
          check("abort_wr", 64'(MemoryWrite), 64'(0));
          check("abort_req", 64'(mem_req), 64'(0));
          check("abort_state", 64'(state_o), 64'(0));
          repeat (2) @(posedge clk);
          #1;
          clr = 1'b1;
          exp_instret = '0; exp_illegal = 1'b0; exp_bus = 1'b0;
          #1;
          check("abort_instret", 64'(instret), 64'(0));
          check("abort_fetch", 64'(state_o), 64'(0));
          mem_ready = 1'b0;
          return;
        end
        mem_ready = (k == mdly);
        @(negedge clk);
        e = '0;
        e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = (op == 7'h23);
        check("mem_state", 64'(state_o), 64'(3));
        check("mem_ctrl", 64'(act), 64'(e));
        tick();
        if (k == mdly) break;
      end
      mem_ready = 1'b0;
      if (mdly >= int'(TIMEOUT)) begin
        exp_bus = 1'b1;
        dead = 1'b1;
        return;
      end
      if (op == 7'h23) begin
        exp_instret++;
        check("instret", 64'(instret), 64'(exp_instret));
        return;
      end
    end

    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    e = '0;
    e.reg_write = 1'b1;
    e.wb_sel = (op == 7'h03) ? 2'b01 : ((op == 7'h6F || op == 7'h67) ? 2'b10 : 2'b00);
    check("wb_state", 64'(state_o), 64'(4));
    check("wb_ctrl", 64'(act), 64'(e));
    tick();
    mem_ready = 1'b0;
    exp_instret++;
    check("instret", 64'(instret), 64'(exp_instret));
  endtask

  task automatic run_or_recover(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] cmp,
                                input int fdly, input int mdly, input int abort);
    bit dead;
    run_instr(op, f3, cmp, fdly, mdly, abort, dead);
    if (dead) begin
      check_trap();
      do_reset();
    end
  endtask

  initial begin
    logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [2:0] seq [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [6:0] op;
    int         r, fd, md;

    do_reset();
    run_or_recover(7'h33, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h03, 3'd2, 3'b000, 0, 3, -1);
    run_or_recover(7'h63, 3'd1, 3'b001, 1, 0, -1);
    run_or_recover(7'h63, 3'd1, 3'b000, 0, 0, -1);
    run_or_recover(7'h63, 3'd6, 3'b100, 2, 0, -1);
    run_or_recover(7'h23, 3'd2, 3'b000, 0, 1, -1);
    run_or_recover(7'h6F, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h67, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h37, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h17, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h13, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h33, 3'd0, 3'b000, int'(TIMEOUT) - 1, 0, -1);
    run_or_recover(7'h03, 3'd2, 3'b000, 0, int'(TIMEOUT) - 1, -1);
    run_or_recover(7'h33, 3'd0, 3'b000, int'(TIMEOUT), 0, -1);
    run_or_recover(7'h7F, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h63, 3'd2, 3'b000, 0, 0, -1);
    run_or_recover(7'h03, 3'd2, 3'b000, 0, int'(TIMEOUT), -1);
    run_or_recover(7'h33, 3'd0, 3'b000, 0, 0, -1);
    run_or_recover(7'h23, 3'd2, 3'b000, 0, 5, 2);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      op = (r == 9) ? 7'($urandom) : legal_ops[r];
      fd = ($urandom_range(0, 15) == 0) ? int'(TIMEOUT) - 1 + int'($urandom_range(0, 1))
                                         : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 15) == 0) ? int'(TIMEOUT) - 1 + int'($urandom_range(0, 1))
                                         : int'($urandom_range(0, 3));
      run_or_recover(op, 3'($urandom), 3'($urandom), fd, md, -1);
    end

    // No-handshake instance: ADD loops FETCH,DECODE,EXEC,WB; instret is 3 bits and wraps.
    do_reset();
    opcode = 7'h33;
    func3 = 3'd0;
    mem_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("nohs_state", 64'(d2_state_o), 64'(seq[c % 4]));
      check("nohs_instret", 64'(d2_instret), 64'((c / 4) % 8));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
